sdram_arbiter: RTL

Burst scheduler between the SDRAM FIFO ports and the SDRAM command engine. It watches the write-FIFO and read-FIFO fill levels and a periodic refresh timer, then issues one command at a time: auto-refresh, write burst or read burst. It also generates the burst addresses. It sits between the write/read FIFOs (fed by traffic sources such as the test pattern generator) and the command/timing engine that drives the SDRAM pins.

---
 rtl/sdram_pkg.sv | 5 +
 rtl/sdram_arbiter_if.sv | 11 +
 rtl/sdram_refresh_timer.sv | 29 ++
 rtl/sdram_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings and arbiter FSM states shared by the SDRAM arbiter slice
package sdram_pkg;
   typedef enum logic [1:0] {CMD_NOP = 2'b00, CMD_REF = 2'b01, CMD_WR = 2'b10, CMD_RD = 2'b11} cmd_t;
   typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_REQ, S_WAIT_DONE} state_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: command handshake between the burst arbiter and the SDRAM command engine
interface sdram_arbiter_if #(parameter int ADDR_W = 24);
   import sdram_pkg::*;
   logic              cmd_req;
   cmd_t              cmd_type;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_ack;
   logic              cmd_done;
   modport master (output cmd_req, cmd_type, cmd_addr, input cmd_ack, cmd_done);
   modport slave (input cmd_req, cmd_type, cmd_addr, output cmd_ack, cmd_done);
endinterface

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh request with sticky overrun flag
module sdram_refresh_timer #(
   parameter int REF_PERIOD = 390
) (
   input  logic clk_50m,
   input  logic rst,
   input  logic en,
   input  logic ref_ack,
   output logic ref_pending,
   output logic ref_overrun
);
   localparam int CW = $clog2(REF_PERIOD);
   logic [CW-1:0] cnt;
   logic tc;
   assign tc = cnt == CW'(REF_PERIOD - 1);
   always_ff @(posedge clk_50m)
      if (rst) begin
         cnt         <= '0;
         ref_pending <= 1'b0;
         ref_overrun <= 1'b0;
      end else if (!en) begin
         cnt         <= '0;
         ref_pending <= 1'b0;
      end else begin
         cnt         <= tc ? '0 : cnt + 1'b1;
         ref_pending <= tc | (ref_pending & ~ref_ack);
         ref_overrun <= ref_overrun | (tc & ref_pending & ~ref_ack);
      end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: schedules refresh, write and read bursts into the SDRAM command engine
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int                BURST_LEN     = 256,
   parameter int                ADDR_W        = 24,
   parameter int                LVL_W         = 11,
   parameter int                RD_FIFO_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] START_ADDR    = '0,
   parameter logic [ADDR_W-1:0] END_ADDR      = 24'hFFFFFF,
   parameter int                REF_PERIOD    = 390
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             sdram_init_done,
   input  logic             rd_enable,
   input  logic [LVL_W-1:0] wr_fifo_level,
   input  logic [LVL_W-1:0] rd_fifo_level,
   sdram_arbiter_if.master  cmd_if,
   output logic             busy,
   output logic             ref_overrun
);
   localparam int CAP = (int'(END_ADDR) - int'(START_ADDR) + 1) / BURST_LEN;
   localparam int AV_W = $clog2(CAP + 1);
   localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(BURST_LEN);
   function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] p);
      return ({1'b0, p} + STEP > {1'b0, END_ADDR}) ? START_ADDR : p + ADDR_W'(BURST_LEN);
   endfunction
   state_t            state, state_n;
   cmd_t              type_q, type_n;
   logic              req_q, req_n, init_q, ref_pending, ref_ack, wr_ok, rd_ok, full;
   logic [ADDR_W-1:0] addr_q, addr_n, wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [AV_W-1:0]   avail, avail_n;
   assign wr_ok   = 32'(wr_fifo_level) >= BURST_LEN;
   assign rd_ok   = rd_enable && avail != '0 && 32'(rd_fifo_level) <= RD_FIFO_DEPTH - BURST_LEN;
   assign full    = avail == AV_W'(CAP);
   assign ref_ack = state == S_REQ && cmd_if.cmd_ack && type_q == CMD_REF;
   sdram_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
      .clk_50m(clk_50m), .rst(rst), .en(init_q), .ref_ack(ref_ack),
      .ref_pending(ref_pending), .ref_overrun(ref_overrun)
   );
   always_comb begin
      state_n  = state;
      req_n    = req_q;
      type_n   = type_q;
      addr_n   = addr_q;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      avail_n  = avail;
      if (!init_q) begin
         state_n  = S_WAIT_INIT;
         req_n    = 1'b0;
         type_n   = CMD_NOP;
         addr_n   = '0;
         wr_ptr_n = START_ADDR;
         rd_ptr_n = START_ADDR;
         avail_n  = '0;
      end else if (state == S_WAIT_INIT) begin
         state_n = S_IDLE;
      end else if (state == S_IDLE) begin
         if (ref_pending || wr_ok || rd_ok) begin
            state_n = S_REQ;
            req_n   = 1'b1;
            type_n  = ref_pending ? CMD_REF : wr_ok ? CMD_WR : CMD_RD;
            addr_n  = ref_pending ? '0 : wr_ok ? wr_ptr : rd_ptr;
         end
      end else if (state == S_REQ) begin
         if (cmd_if.cmd_ack) begin
            state_n = S_WAIT_DONE;
            req_n   = 1'b0;
         end
      end else if (cmd_if.cmd_done) begin
         state_n = S_IDLE;
         // a write into a full ring overwrites the oldest burst, so the read side skips it
         if (type_q == CMD_WR) begin
            wr_ptr_n = adv(wr_ptr);
            rd_ptr_n = full ? adv(rd_ptr) : rd_ptr;
            avail_n  = full ? avail : avail + 1'b1;
         end
         if (type_q == CMD_RD) begin
            rd_ptr_n = adv(rd_ptr);
            avail_n  = avail - 1'b1;
         end
      end
   end
   always_ff @(posedge clk_50m)
      if (rst) begin
         init_q <= 1'b0;
         state  <= S_WAIT_INIT;
         req_q  <= 1'b0;
         type_q <= CMD_NOP;
         addr_q <= '0;
         wr_ptr <= START_ADDR;
         rd_ptr <= START_ADDR;
         avail  <= '0;
      end else begin
         init_q <= sdram_init_done;
         state  <= state_n;
         req_q  <= req_n;
         type_q <= type_n;
         addr_q <= addr_n;
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         avail  <= avail_n;
      end
   assign cmd_if.cmd_req  = req_q;
   assign cmd_if.cmd_type = type_q;
   assign cmd_if.cmd_addr = addr_q;
   assign busy = state == S_REQ || state == S_WAIT_DONE;
endmodule
